pc_sequencer: RTL

- Consumer side of the decoder's NPCOp/nop interface. It holds the architectural PC, computes the next PC from the NPCOp the decoder returns, and drives the decoder's nop input.
- Sequences reset entry, instruction-memory wait cycles, stalls and exception entry: EPC capture, vector redirect, one-cycle bubble.
- Sits between instruction memory, the decoder and the register file read port (for JR).

---
 rtl/pc_sequencer.sv | 115 +++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// PC sequencer: boot, fetch wait, stall, branch/jump/JR and exception entry.
// Optional NPC_ERET_EN: npc_op=5 returns to epc+4 instead of trapping.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [2:0]  npc_op,
    input  logic [15:0] imm16,
    input  logic [25:0] target26,
    input  logic [31:0] rs_data,
    input  logic        if_ready,
    input  logic        stall,
    output logic [31:0] pc,
    output logic        if_req,
    output logic        nop,
    output logic [31:0] epc,
    output logic [1:0]  exc_cause,
    output logic        exc_pulse
);

    typedef enum logic [1:0] {BOOT, RUN, EXC_FLUSH} state_t;

    state_t      state, state_nx;
    logic        fire, exc, advance;
    logic        is_b, is_j, is_jr, is_eret, illegal, misal;
    logic [31:0] pc4, next_pc;

    assign fire  = (state == RUN) & if_ready & ~stall;
    assign is_b  = (npc_op == 3'd1);
    assign is_j  = (npc_op == 3'd2);
    assign is_jr = (npc_op == 3'd3);
    assign misal = is_jr & (rs_data[1:0] != 2'b00);

`ifdef NPC_ERET_EN
    assign is_eret = (npc_op == 3'd5);
    assign illegal = (npc_op == 3'd4) | (npc_op >= 3'd6);
`else
    assign is_eret = 1'b0;
    assign illegal = (npc_op >= 3'd4);
`endif

    assign exc     = fire & (illegal | misal);
    assign advance = fire & ~exc;

    assign pc4 = pc + 32'd4;

    always_comb begin
        next_pc = pc4;
        unique case (1'b1)
            is_b:    next_pc = pc4 + {{14{imm16[15]}}, imm16, 2'b00};
            is_j:    next_pc = {pc4[31:28], target26, 2'b00};
            is_jr:   next_pc = rs_data;
            is_eret: next_pc = epc + 32'd4;
            default: next_pc = pc4;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state <= BOOT;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            BOOT:      state_nx = RUN;
            RUN:       state_nx = exc ? EXC_FLUSH : RUN;
            EXC_FLUSH: state_nx = RUN;
            default:   state_nx = BOOT;
        endcase
    end

    always_comb begin
        nop       = 1'b1;
        if_req    = 1'b0;
        exc_pulse = 1'b0;
        unique case (state)
            BOOT: begin
                nop    = 1'b1;
                if_req = 1'b0;
            end
            RUN: begin
                nop    = ~if_ready;
                if_req = 1'b1;
            end
            EXC_FLUSH: begin
                nop       = 1'b1;
                exc_pulse = 1'b1;
            end
            default: nop = 1'b1;
        endcase
    end

    // The flush state is the cycle right after entry, so it doubles as the strobe
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc        <= RESET_PC;
            epc       <= 32'd0;
            exc_cause <= 2'd0;
        end else if (exc) begin
            epc       <= pc;
            pc        <= EXC_VECTOR;
            exc_cause <= misal ? 2'd2 : 2'd1;
        end else if (advance) begin
            pc <= next_pc;
            if (is_eret)
                exc_cause <= 2'd0;
        end
    end

endmodule
